muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the multicycle MIPS core; implements the HI/LO register pair and the MULT, MULTU, DIV, DIVU, MTHI and MTLO operations.
- Sits beside the ALU. The controller issues an operation with a start pulse and stalls on busy; the datapath reads hi/lo for MFHI/MFLO.
- Uses a shift-add multiplier and a restoring divider; each processes one bit per cycle.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; must be at least 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  accept op/a/b on this edge when not busy
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are ignored
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO data)
- b  input  WIDTH  rt operand (multiplier / divisor)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle
- dbz  output  1  sticky divide-by-zero flag; cleared by the next accepted start
- hi  output  WIDTH  HI register (upper product / remainder)
- lo  output  WIDTH  LO register (lower product / quotient)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; busy=0, done=0, dbz=0, hi=0, lo=0; iteration counter 0. Reset mid-operation abandons the operation; no partial result reaches hi/lo.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1 on edge E0:
  - op 100: hi<=a, done=1 the next cycle, busy stays 0.
  - op 101: lo<=a, done=1 the next cycle, busy stays 0.
  - op 11x: no effect; no done.
  - op MULT/MULTU: go to MUL.
  - op DIV/DIVU with b!=0: go to DIV.
  - op DIV/DIVU with b==0: hi<=a, lo<=all-ones, dbz<=1, done=1 the next cycle, busy stays 0.
- Signed ops (MULT, DIV) take operand magnitudes at E0 and record the result signs:
  - product sign = a[MSB]^b[MSB];
  - quotient sign = a[MSB]^b[MSB];
  - remainder sign = a[MSB].
- Unsigned ops record positive signs.
- MUL/DIV: exactly WIDTH iteration cycles, then FIX for one cycle.
  - MUL: 2*WIDTH-bit accumulator, shift-add on the LSB of the multiplier.
  - DIV: restoring divider, one quotient bit per cycle.
- FIX: apply two's-complement negation per the recorded signs, then write hi/lo and return to IDLE.
- Timing: busy=1 from the cycle after E0 through FIX. hi/lo update on edge E0+WIDTH+1, with done=1 and busy=0 in the following cycle. Total latency is WIDTH+2 cycles from start to done.
- hi/lo hold their old values throughout an operation; they change only on FIX, MTHI/MTLO or divide-by-zero.
- start while busy is ignored entirely: no queueing, no effect on the current operation.
- Edge cases:
  - MULT of the most-negative value by itself gives the exact 2*WIDTH-bit product.
  - DIV of most-negative by -1 gives lo=most-negative, hi=0 (wraps, no flag).
- done is never asserted for two consecutive cycles except for back-to-back MTHI/MTLO/divide-by-zero starts.
- dbz is cleared on any accepted start; the divide-by-zero case then sets it again.

Optional Feature:
- Macro MULDIV_EARLY_EXIT_EN.
- Defined: MUL leaves to FIX at the end of the first iteration cycle in which the remaining unshifted multiplier bits are all zero. The accumulator is aligned by the outstanding shift count, so the result is identical. Latency is 2 + the index of the highest set bit of |b|, plus 1; b==0 completes with latency 3. DIV is unaffected.
- Not defined: MUL always takes WIDTH iterations.

Test Plan:
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=-7 b=6 -> hi=0xFFFFFFFF, lo=0xFFFFFFD6. DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> done on the next cycle, hi=100, lo=0xFFFFFFFF, dbz=1. Then MTLO a=5 -> dbz=0, lo=5, hi unchanged.
- Start DIVU 100/7 and pulse start with MTHI a=9 at cycle 5 -> MTHI ignored; final lo=14, hi=2.
- Reset asserted mid-MULT at cycle 10 -> busy=0 and hi=lo=0 immediately; the next MULTU 3*4 gives lo=12, hi=0.
- With MULDIV_EARLY_EXIT_EN: MULTU a=5 b=3 -> done at latency 4, lo=15. Without the macro: same result at latency 34.

Source files
------------

// File: rtl/muldiv_if.sv
// Handshake and result bus between the controller and the HI/LO multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input busy, done, dbz, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, dbz, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Optional macro MULDIV_EARLY_EXIT_EN lets MUL finish once the remaining multiplier bits are all zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             state_q;
    logic               busy_q, done_q, dbz_q, div_q, neg_lo_q, neg_hi_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q, mcand_q, mplier_q;
    logic [2*WIDTH-1:0] acc_q;

    logic               sgn_s, res_neg_s, mul_last_s, cnt_last_s;
    logic [WIDTH:0]     mul_sum_s, div_sh_s, div_diff_s;
    logic [2*WIDTH-1:0] mul_acc_s, div_acc_s, prod_s;

    function automatic logic [WIDTH-1:0] neg_w_f(input logic cond, input logic [WIDTH-1:0] v);
        neg_w_f = cond ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w_f(input logic cond, input logic [2*WIDTH-1:0] v);
        neg_2w_f = cond ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Per-cycle datapath step for both iterative engines and the final sign fix-up.
    always_comb begin
        sgn_s      = ~bus.op[0];
        res_neg_s  = sgn_s & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        cnt_last_s = (cnt_q == CW'(WIDTH-1));
        mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mul_acc_s  = {mul_sum_s, acc_q[WIDTH-1:1]};
        div_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s = div_sh_s - {1'b0, mcand_q};
        if (div_sh_s >= {1'b0, mcand_q}) begin
            div_acc_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_s = {div_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
`ifdef MULDIV_EARLY_EXIT_EN
        mul_last_s = cnt_last_s || (mplier_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});
`else
        mul_last_s = cnt_last_s;
`endif
        prod_s = neg_2w_f(neg_lo_q, acc_q);
    end

    // Control FSM together with the HI/LO result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'b100: begin
                                hi_q   <= bus.a;
                                dbz_q  <= 1'b0;
                                done_q <= 1'b1;
                            end
                            3'b101: begin
                                lo_q   <= bus.a;
                                dbz_q  <= 1'b0;
                                done_q <= 1'b1;
                            end
                            3'b000, 3'b001: begin
                                state_q  <= S_MUL;
                                busy_q   <= 1'b1;
                                dbz_q    <= 1'b0;
                                div_q    <= 1'b0;
                                cnt_q    <= {CW{1'b0}};
                                acc_q    <= {(2*WIDTH){1'b0}};
                                mcand_q  <= neg_w_f(sgn_s & bus.a[WIDTH-1], bus.a);
                                mplier_q <= neg_w_f(sgn_s & bus.b[WIDTH-1], bus.b);
                                neg_lo_q <= res_neg_s;
                                neg_hi_q <= 1'b0;
                            end
                            3'b010, 3'b011: begin
                                if (bus.b == {WIDTH{1'b0}}) begin
                                    hi_q   <= bus.a;
                                    lo_q   <= {WIDTH{1'b1}};
                                    dbz_q  <= 1'b1;
                                    done_q <= 1'b1;
                                end else begin
                                    state_q  <= S_DIV;
                                    busy_q   <= 1'b1;
                                    dbz_q    <= 1'b0;
                                    div_q    <= 1'b1;
                                    cnt_q    <= {CW{1'b0}};
                                    acc_q    <= {{WIDTH{1'b0}}, neg_w_f(sgn_s & bus.a[WIDTH-1], bus.a)};
                                    mcand_q  <= neg_w_f(sgn_s & bus.b[WIDTH-1], bus.b);
                                    mplier_q <= {WIDTH{1'b0}};
                                    neg_lo_q <= res_neg_s;
                                    neg_hi_q <= sgn_s & bus.a[WIDTH-1];
                                end
                            end
                            default: begin
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_MUL: begin
`ifdef MULDIV_EARLY_EXIT_EN
                    // Early exit leaves the product scaled up by the skipped shifts; undo that here.
                    if (mul_last_s) begin
                        acc_q <= mul_acc_s >> (CW'(WIDTH-1) - cnt_q);
                    end else begin
                        acc_q <= mul_acc_s;
                    end
`else
                    acc_q <= mul_acc_s;
`endif
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (mul_last_s) begin
                        state_q <= S_FIX;
                    end
                end
                S_DIV: begin
                    acc_q <= div_acc_s;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_last_s) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (div_q) begin
                        lo_q <= neg_w_f(neg_lo_q, acc_q[WIDTH-1:0]);
                        hi_q <= neg_w_f(neg_hi_q, acc_q[2*WIDTH-1:WIDTH]);
                    end else begin
                        lo_q <= prod_s[WIDTH-1:0];
                        hi_q <= prod_s[2*WIDTH-1:WIDTH];
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] m_hi, m_lo;
    logic         m_dbz;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int msb_idx(input logic [W-1:0] v);
        int r = -1;
        for (int i = 0; i < W; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Reference model: updates m_hi/m_lo/m_dbz and returns expected latency and busy cycles.
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cyc);
        longint sa, sb, q, r;
        logic [63:0] p;
        logic [W-1:0] bm;
        sa = $signed(a);
        sb = $signed(b);
        lat = W + 2;
        busy_cyc = W + 1;
        case (op)
            3'd0, 3'd1: begin
                if (op == 3'd0) begin
                    p  = sa * sb;
                    bm = (sb < 0) ? W'(-sb) : b;
                end else begin
                    p  = 64'(a) * 64'(b);
                    bm = b;
                end
                m_hi = p[63:32];
                m_lo = p[31:0];
                m_dbz = 1'b0;
`ifdef MULDIV_EARLY_EXIT_EN
                lat = (bm == '0) ? 3 : msb_idx(bm) + 3;
                busy_cyc = lat - 1;
`endif
            end
            3'd2, 3'd3: begin
                if (b == '0) begin
                    m_hi = a; m_lo = '1; m_dbz = 1'b1;
                    lat = 1; busy_cyc = 0;
                end else begin
                    if (op == 3'd2) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'(64'(a) / 64'(b));
                        r = longint'(64'(a) % 64'(b));
                    end
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                    m_dbz = 1'b0;
                end
            end
            3'd4: begin m_hi = a; m_dbz = 1'b0; lat = 1; busy_cyc = 0; end
            default: begin m_lo = a; m_dbz = 1'b0; lat = 1; busy_cyc = 0; end
        endcase
    endtask

    // Issue one op, optionally pulsing an MTHI a=9 while busy at cycle intr_at, then check everything.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int intr_at);
        int exp_lat, exp_busy, lat, busy_cyc;
        logic hold_bad;
        logic [W-1:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        model(op, a, b, exp_lat, exp_busy);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        lat = 0; busy_cyc = 0; hold_bad = 1'b0;
        for (int i = 1; i <= W + 10; i++) begin
            @(negedge clk);
            if (bus.busy) busy_cyc++;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.hi !== old_hi || bus.lo !== old_lo) hold_bad = 1'b1;
            bus.start = 1'b0;
            if (i == intr_at) begin
                bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'd9;
            end
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
        check({tag, ".hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(m_lo));
        check({tag, ".dbz"}, 64'(bus.dbz), 64'(m_dbz));
        check({tag, ".hold"}, 64'(hold_bad), 64'd0);
    endtask

    initial begin
        int seen_done;
        logic [2:0] rop;
        logic [W-1:0] ra, rb;
        reset = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.dbz", 64'(bus.dbz), 64'd0);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);
        reset = 1'b1;

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max.hi_const", 64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
        run_op("mult_m7x6", 3'd0, 32'hFFFF_FFF9, 32'd6, 0);
        run_op("div_m7d2", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7d2.lo_const", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
        run_op("divu_dbz", 3'd3, 32'd100, 32'd0, 0);
        run_op("mtlo_5", 3'd5, 32'd5, 32'd0, 0);
        run_op("divu_intr", 3'd3, 32'd100, 32'd7, 5);
        check("divu_intr.lo_const", 64'(bus.lo), 64'd14);
        run_op("mult_minmin", 3'd0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("multu_5x3", 3'd1, 32'd5, 32'd3, 0);
        run_op("multu_bzero", 3'd1, 32'd77, 32'd0, 0);
        run_op("mthi_1", 3'd4, 32'hA5A5_0001, 32'd0, 0);
        run_op("mtlo_2", 3'd5, 32'h5A5A_0002, 32'd0, 0);

        // Reserved op must produce nothing.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd6; bus.a = 32'h1234_5678;
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done || bus.busy) seen_done++;
        end
        check("op110.no_done", 64'(seen_done), 64'd0);
        check("op110.hi", 64'(bus.hi), 64'(m_hi));

        // Reset in the middle of a MULT.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd123; bus.b = 32'd456;
        repeat (10) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b0;
        #1;
        check("midreset.busy", 64'(bus.busy), 64'd0);
        check("midreset.hi", 64'(bus.hi), 64'd0);
        check("midreset.lo", 64'(bus.lo), 64'd0);
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_op("after_reset_3x4", 3'd1, 32'd3, 32'd4, 0);

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 5));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (k % 9 == 0) ra = 32'h8000_0000;
            run_op($sformatf("rand%0d_op%0d", k, rop), rop, ra, rb, (k % 4 == 0) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
